sync_gen: RTL and testbench
===========================

# sync_gen

Periodic sync-pulse generator that produces the single-cycle `sync_out` strobe consumed by the downstream sync delay stage and the rest of the DSP chain. It aligns to a rising edge on an external reference (e.g. 1PPS or board sync) after being armed by software, then emits a pulse every `period` cycles until re-armed or reset. It also provides status and a pulse counter for register readback.

## Interface
- `PERIOD_WIDTH`, 32, width of the period input and the internal cycle counter
- `CNT_WIDTH`, 16, width of the emitted-pulse counter
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `arm`  in  1  single-cycle arm/re-arm request
- `ext_sync`  in  1  external reference, already synchronous to `clk`; rising edge is the alignment event
- `period`  in  PERIOD_WIDTH  pulse spacing in cycles; sampled on entry to RUN and at every wrap
- `sync_out`  out  1  registered single-cycle sync pulse
- `armed`  out  1  high while in ARMED
- `running`  out  1  high while in RUN
- `count`  out  PERIOD_WIDTH  current cycle position within the period
- `sync_cnt`  out  CNT_WIDTH  number of pulses emitted since reset, wraps modulo 2^CNT_WIDTH

## Operation
- Edge detect: `ext_q` registers `ext_sync` every cycle, reset value 0. An edge is `ext_sync & ~ext_q`. A level held high produces exactly one edge.
- States: IDLE (reset state), ARMED, RUN. `armed` and `running` decode the state combinationally from the state register.
- IDLE: no pulses; `count` = 0. `arm` -> ARMED. An edge in IDLE is ignored, including when it arrives in the same cycle as `arm`.
- ARMED: waits for an edge. On an edge, the block asserts `sync_out` next cycle, loads `count` <= 0 and `period_q` <= `period`, and goes to RUN. `arm` in ARMED is a no-op, and the edge wins if both occur in the same cycle.
- RUN:
  - If `period_q` = 0: `count` holds 0 and no further pulses are emitted.
  - Otherwise `count` increments each cycle. When `count == period_q-1`, the block asserts `sync_out` next cycle, sets `count` <= 0 and `period_q` <= `period`.
  - With `period_q` = 1, `sync_out` is high every cycle.
- `arm` in RUN: go to ARMED and set `count` <= 0. `arm` has priority over a wrap in the same cycle, so that pulse is suppressed.
- Edges in RUN are ignored; realignment always requires `arm`.
- `sync_cnt` increments by 1 on each cycle `sync_out` is registered high.
- Changes to `period` mid-period take effect only at the next wrap (or the next RUN entry).
- `period` is unsigned. Compare is full width with no saturation.

## Timing
- Reset values: `sync_out`=0, `armed`=0, `running`=0, `count`=0, `sync_cnt`=0, `ext_q`=0, state=IDLE, `period_q`=0.
- `rst` overrides everything in the same cycle, including mid-RUN and mid-pulse. `sync_out` is 0 in the cycle after `rst` is sampled.
- Alignment latency: edge sampled at clock edge E -> `sync_out` high for the cycle following E. `running` is high from the same cycle.
- Periodic spacing: consecutive `sync_out` pulses are exactly `period_q` cycles apart, measured rising edge to rising edge.
- `arm` sampled at E -> `armed` high from the cycle following E.
- `sync_out` is never high for two consecutive cycles unless `period_q` = 1.

## Test plan
- Reset, `arm`, `period`=8, then raise `ext_sync` at cycle 20 and hold it high.
  - Required: pulses at cycles 21, 29, 37, …
  - Required: `sync_cnt` increments per pulse; no extra pulse from the held level.
- `ext_sync` edge with no `arm`.
  - Required: no pulse, `armed`=0, `running`=0.
- In RUN with `period`=8, change `period` to 4 mid-period.
  - Required: the current gap stays 8; subsequent gaps are 4.
- In RUN, assert `arm` on the cycle where `count`=7 (`period_q`=8).
  - Required: no pulse, `armed`=1, `count`=0.
  - Required: the next edge realigns with latency 1.
- `period`=1, then `period`=0 on separate runs.
  - `period`=1: `sync_out` high every cycle.
  - `period`=0: only the alignment pulse, `count` stays 0.
- Assert `rst` while `sync_out`=1 in RUN.
  - Required: all outputs 0 and IDLE next cycle; a later edge without `arm` produces no pulse.

Source files
------------

// File: rtl/sync_gen.sv
// Periodic sync-pulse generator: armed by software, aligned to the first rising
// edge of an external reference, then strobes sync_out every period cycles.
module sync_gen #(
    parameter int PERIOD_WIDTH = 32,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    arm,
    input  logic                    ext_sync,
    input  logic [PERIOD_WIDTH-1:0] period,
    output logic                    sync_out,
    output logic                    armed,
    output logic                    running,
    output logic [PERIOD_WIDTH-1:0] count,
    output logic [CNT_WIDTH-1:0]    sync_cnt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    localparam logic [PERIOD_WIDTH-1:0] P_ONE = {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]    C_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]              state;
    logic                    ext_q;
    logic [PERIOD_WIDTH-1:0] period_q;
    logic                    edge_det;
    logic                    wrap;
    logic                    fire;

    assign edge_det = ext_sync & ~ext_q;
    // A zero period never wraps, so the run stays parked after the alignment pulse.
    assign wrap     = (period_q != '0) && (count == period_q - P_ONE);
    // arm in RUN beats a wrap in the same cycle, suppressing that pulse.
    assign fire     = ((state == ST_ARMED) && edge_det) ||
                      ((state == ST_RUN) && !arm && wrap);

    assign armed   = (state == ST_ARMED);
    assign running = (state == ST_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            ext_q    <= 1'b0;
            period_q <= '0;
            count    <= '0;
            sync_out <= 1'b0;
            sync_cnt <= '0;
        end else begin
            ext_q    <= ext_sync;
            sync_out <= fire;
            if (fire) begin
                sync_cnt <= sync_cnt + C_ONE;
            end
            case (state)
                ST_IDLE: begin
                    count <= '0;
                    if (arm) begin
                        state <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (edge_det) begin
                        state    <= ST_RUN;
                        count    <= '0;
                        period_q <= period;
                    end
                end
                ST_RUN: begin
                    if (arm) begin
                        state <= ST_ARMED;
                        count <= '0;
                    end else if (period_q == '0) begin
                        count <= '0;
                    end else if (wrap) begin
                        count    <= '0;
                        period_q <= period;
                    end else begin
                        count <= count + P_ONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sync_gen.sv
// Bench for sync_gen: a time-based model (last pulse time + latched period)
// predicts every output each cycle; directed scenarios pin it with literals.
module tb_sync_gen;

    logic        clk;
    logic        rst;
    logic        arm;
    logic        ext_sync;
    logic [31:0] period;
    logic        sync_out;
    logic        armed;
    logic        running;
    logic [31:0] count;
    logic [15:0] sync_cnt;

    sync_gen #(.PERIOD_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .arm(arm), .ext_sync(ext_sync), .period(period),
        .sync_out(sync_out), .armed(armed), .running(running),
        .count(count), .sync_cnt(sync_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mode: 0 idle, 1 armed, 2 running; t0 is the cycle of the latest pulse
    typedef struct {
        int          mode;
        logic        ext;
        int          t0;
        logic [31:0] pq;
        logic        sync;
        logic [15:0] cnt;
    } model_t;

    model_t      cur;
    model_t      nxt;
    int          cyc;
    int          base;
    bit          chk_en;
    bit          rec_en;
    int          errors;
    int          checks;
    logic [31:0] exp_q[$];
    logic [31:0] pulse_q[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, got, exp);
        end
    endtask

    // Outputs expected in the cycle after the coming clock edge.
    task automatic predict();
        logic edge_v;
        edge_v   = ext_sync & ~cur.ext;
        nxt      = cur;
        nxt.sync = 1'b0;
        if (rst) begin
            nxt.mode = 0;
            nxt.ext  = 1'b0;
            nxt.t0   = 0;
            nxt.pq   = '0;
            nxt.cnt  = '0;
        end else begin
            nxt.ext = ext_sync;
            if (cur.mode == 0) begin
                if (arm) nxt.mode = 1;
            end else if (cur.mode == 1) begin
                if (edge_v) begin
                    nxt.mode = 2;
                    nxt.sync = 1'b1;
                    nxt.t0   = cyc + 1;
                    nxt.pq   = period;
                    nxt.cnt  = cur.cnt + 16'd1;
                end
            end else begin
                if (arm) begin
                    nxt.mode = 1;
                end else if (cur.pq != 0 && (cyc + 1 - cur.t0) == int'(cur.pq)) begin
                    nxt.sync = 1'b1;
                    nxt.t0   = cyc + 1;
                    nxt.pq   = period;
                    nxt.cnt  = cur.cnt + 16'd1;
                end
            end
        end
    endtask

    // Inputs given here are driven during the cycle that begins at this edge.
    task automatic step(input logic r, input logic a, input logic e, input logic [31:0] p);
        @(posedge clk);
        #1;
        cur      = nxt;
        cyc      = cyc + 1;
        chk_en   = 1'b1;
        rst      = r;
        arm      = a;
        ext_sync = e;
        period   = p;
        predict();
    endtask

    task automatic start_rec();
        base   = cyc;
        rec_en = 1'b1;
        pulse_q.delete();
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic check_pulses(input string name);
        int n;
        chk({name, "_num"}, pulse_q.size(), exp_q.size());
        n = (pulse_q.size() < exp_q.size()) ? pulse_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk(name, pulse_q[i], exp_q[i]);
        end
        pulse_q.delete();
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("sync_out", {31'd0, sync_out}, {31'd0, cur.sync});
            chk("armed", {31'd0, armed}, (cur.mode == 1) ? 32'd1 : 32'd0);
            chk("running", {31'd0, running}, (cur.mode == 2) ? 32'd1 : 32'd0);
            chk("count", count, (cur.mode == 2 && cur.pq != 0) ? 32'(cyc - cur.t0) : 32'd0);
            chk("sync_cnt", {16'd0, sync_cnt}, {16'd0, cur.cnt});
            if (rec_en && sync_out) pulse_q.push_back(32'(cyc - base));
        end
    end

    initial begin
        logic r, a, e;
        logic [31:0] p;
        cur      = '{0, 1'b0, 0, 32'd0, 1'b0, 16'd0};
        cyc      = -1;
        base     = 0;
        chk_en   = 1'b0;
        rec_en   = 1'b0;
        errors   = 0;
        checks   = 0;
        rst      = 1'b1;
        arm      = 1'b0;
        ext_sync = 1'b0;
        period   = 32'd0;
        predict();

        // Arm, period 8, reference rises at cycle 20 and stays high.
        step(1, 0, 0, 8);
        start_rec();
        step(0, 1, 0, 8);
        for (int k = 2; k < 20; k++) step(0, 0, 0, 8);
        for (int k = 20; k <= 40; k++) step(0, 0, 1, 8);
        settle();
        exp_q = '{32'd21, 32'd29, 32'd37};
        check_pulses("align_pulses");
        chk("align_sync_cnt", {16'd0, sync_cnt}, 32'd3);

        // Edge without arm, then arm coinciding with an edge in IDLE.
        step(1, 0, 0, 5);
        start_rec();
        step(0, 0, 0, 5);
        step(0, 0, 1, 5);
        step(0, 0, 0, 5);
        settle();
        chk("noarm_armed", {31'd0, armed}, 32'd0);
        chk("noarm_running", {31'd0, running}, 32'd0);
        step(0, 1, 1, 5);
        for (int k = 0; k < 3; k++) step(0, 0, 1, 5);
        settle();
        chk("armedge_armed", {31'd0, armed}, 32'd1);
        chk("armedge_running", {31'd0, running}, 32'd0);
        exp_q.delete();
        check_pulses("noarm_pulses");

        // Period drops from 8 to 4 mid-period.
        step(1, 0, 0, 8);
        step(0, 1, 0, 8);
        step(0, 0, 0, 8);
        step(0, 0, 1, 8);
        start_rec();
        for (int j = 1; j <= 21; j++) step(0, 0, 1, (j >= 3) ? 32'd4 : 32'd8);
        settle();
        exp_q = '{32'd1, 32'd9, 32'd13, 32'd17, 32'd21};
        check_pulses("perchg_pulses");

        // Re-arm on the count==7 cycle, then realign.
        step(1, 0, 0, 8);
        step(0, 1, 0, 8);
        step(0, 0, 0, 8);
        step(0, 0, 1, 8);
        start_rec();
        for (int j = 1; j <= 7; j++) step(0, 0, 1, 8);
        step(0, 1, 1, 8);
        step(0, 0, 0, 8);
        settle();
        chk("rearm_armed", {31'd0, armed}, 32'd1);
        chk("rearm_count", count, 32'd0);
        chk("rearm_sync", {31'd0, sync_out}, 32'd0);
        exp_q = '{32'd1};
        check_pulses("rearm_pulses");
        step(0, 0, 1, 8);
        step(0, 0, 1, 8);
        settle();
        chk("realign_sync", {31'd0, sync_out}, 32'd1);
        chk("realign_running", {31'd0, running}, 32'd1);

        // Period 1: a pulse every cycle.
        step(1, 0, 0, 1);
        step(0, 1, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 1, 1);
        start_rec();
        for (int j = 1; j <= 10; j++) step(0, 0, 1, 1);
        settle();
        exp_q.delete();
        for (int j = 1; j <= 10; j++) exp_q.push_back(32'(j));
        check_pulses("p1_pulses");

        // Period 0: alignment pulse only.
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        start_rec();
        for (int j = 1; j <= 15; j++) step(0, 0, 1, 0);
        settle();
        exp_q = '{32'd1};
        check_pulses("p0_pulses");
        chk("p0_count", count, 32'd0);
        chk("p0_running", {31'd0, running}, 32'd1);

        // Reset while the pulse is high, then an edge with no arm.
        step(1, 0, 0, 8);
        step(0, 1, 0, 8);
        step(0, 0, 0, 8);
        step(0, 0, 1, 8);
        start_rec();
        step(1, 0, 1, 8);
        settle();
        chk("rstpulse_sync_before", {31'd0, sync_out}, 32'd1);
        step(0, 0, 0, 8);
        settle();
        chk("rst_sync", {31'd0, sync_out}, 32'd0);
        chk("rst_armed", {31'd0, armed}, 32'd0);
        chk("rst_running", {31'd0, running}, 32'd0);
        chk("rst_count", count, 32'd0);
        chk("rst_sync_cnt", {16'd0, sync_cnt}, 32'd0);
        for (int j = 0; j < 4; j++) step(0, 0, 1, 8);
        settle();
        exp_q = '{32'd1};
        check_pulses("rst_pulses");

        // Randomized traffic.
        rec_en = 1'b0;
        e = 1'b0;
        p = 32'd6;
        for (int k = 0; k < 3000; k++) begin
            r = ($urandom_range(0, 199) == 0);
            a = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 7) == 0) e = ~e;
            if ($urandom_range(0, 19) == 0) p = 32'($urandom_range(0, 12));
            step(r, a, e, p);
        end
        settle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
